modem_symbol_packer: RTL and testbench

Runtime-configurable bit-to-symbol packer at the front of the modem TX chain. It accepts a framed stream of DATA_W-bit words and slices it MSB-first into symbol indices of 1 to 4 bits, selected per frame: BPSK (1), QPSK (2), PSK8 (3) or QAM16 (4). Its output feeds the constellation mapper over a valid/ready handshake. It extends the modulation set with QAM16, generalises the input width, and handles frame boundaries by zero-padding partial final symbols.

---
 rtl/modem_symbol_packer.sv | 118 +++++++++++
 tb/tb_modem_symbol_packer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/modem_symbol_packer.sv
// Framed bit-to-symbol packer: slices DATA_W-bit words MSB-first into 1..4-bit
// symbol indices (BPSK/QPSK/PSK8/QAM16), zero-padding the final partial symbol.
module modem_symbol_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SYM_W  = 4
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic [1:0]        i_mod,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  output logic [SYM_W-1:0]  o_symbol,
  output logic [1:0]        o_mod,
  output logic              o_last,
  input  logic              i_ready
);

  localparam int unsigned BUF_W = DATA_W + 3;
  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   bits_q, bits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic               sof_q, sof_d;
  logic [1:0]         mod_d;
  logic [2:0]         sym_sz_q, sym_sz_d;
  logic               in_fire, out_fire;
  logic               ready_d, valid_d, last_d;
  logic [SYM_W-1:0]   symbol_d;

  assign sym_sz_q = 3'(o_mod) + 3'd1;

  // Next-state for the bit buffer, then the output decode of that next state
  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    sof_d    = sof_q;
    mod_d    = o_mod;
    in_fire  = i_valid && o_ready;
    out_fire = o_valid && i_ready;

    case (state_q)
      IDLE, FILL: begin
        if (in_fire) begin
          // Buffered bits below cnt are always zero, so OR appends the new word
          bits_d = bits_q | (BUF_W'({i_data, 3'b000}) >> cnt_q);
          cnt_d  = cnt_q + CNT_W'(DATA_W);
          if (sof_q) begin
            mod_d = i_mod;
            sof_d = 1'b0;
          end
          if (i_last) flush_d = 1'b1;
        end
      end
      EMIT, FLUSH: begin
        if (out_fire) begin
          if (o_last) begin
            bits_d  = '0;
            cnt_d   = '0;
            flush_d = 1'b0;
            sof_d   = 1'b1;
          end else begin
            bits_d = bits_q << sym_sz_q;
            cnt_d  = cnt_q - CNT_W'(sym_sz_q);
          end
        end
      end
      default: ;
    endcase

    sym_sz_d = 3'(mod_d) + 3'd1;

    if (flush_d)                              state_d = FLUSH;
    else if (cnt_d >= CNT_W'(sym_sz_d))       state_d = EMIT;
    else if (sof_d)                           state_d = IDLE;
    else                                      state_d = FILL;

    valid_d  = (cnt_d >= CNT_W'(sym_sz_d)) || (flush_d && (cnt_d != '0));
    ready_d  = !flush_d && (cnt_d < CNT_W'(sym_sz_d));
    last_d   = flush_d && (cnt_d <= CNT_W'(sym_sz_d)) && valid_d;
    symbol_d = bits_d[BUF_W-1 -: SYM_W] >> (3'(SYM_W) - sym_sz_d);
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q  <= IDLE;
      bits_q   <= '0;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      sof_q    <= 1'b1;
      o_mod    <= 2'd0;
      o_ready  <= 1'b0;
      o_valid  <= 1'b0;
      o_symbol <= '0;
      o_last   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bits_q   <= bits_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      sof_q    <= sof_d;
      o_mod    <= mod_d;
      o_ready  <= ready_d;
      o_valid  <= valid_d;
      o_symbol <= symbol_d;
      o_last   <= last_d;
    end
  end

endmodule

// File: tb/tb_modem_symbol_packer.sv
// Directed, table-driven bench for modem_symbol_packer (DATA_W = 8).
module tb_modem_symbol_packer;

  logic       iclk = 1'b0;
  logic       ireset_n;
  logic [1:0] i_mod;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_last;
  logic       o_ready;
  logic       o_valid;
  logic [3:0] o_symbol;
  logic [1:0] o_mod;
  logic       o_last;
  logic       i_ready;

  int n_checks = 0;
  int n_errors = 0;

  modem_symbol_packer #(.DATA_W(8), .SYM_W(4)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .i_mod(i_mod), .i_valid(i_valid),
    .i_data(i_data), .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid),
    .o_symbol(o_symbol), .o_mod(o_mod), .o_last(o_last), .i_ready(i_ready)
  );

  always #5 iclk = ~iclk;

  // One frame: mod on first word, mod2 on later words; words and expected
  // symbols packed first-in-top (8 bits per word, 4 bits per symbol).
  typedef struct {
    logic [1:0]  mod;
    logic [1:0]  mod2;
    int          nw;
    logic [23:0] words;
    int          nexp;
    logic [31:0] exp;
    bit          stall;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int         k = 0;
    int         wi = 0;
    bit         sent_all = 1'b0;
    bit         hold = 1'b0;
    logic [3:0] hsym = '0;
    logic       hlast = 1'b0;
    logic [3:0] esym;
    for (int cyc = 0; cyc < 300 && k < v.nexp; cyc++) begin
      @(negedge iclk);
      i_ready = v.stall ? (cyc % 3 == 0) : 1'b1;
      if (hold && o_valid) begin
        check($sformatf("v%0d_hold_sym", idx), 32'(o_symbol), 32'(hsym));
        check($sformatf("v%0d_hold_last", idx), 32'(o_last), 32'(hlast));
      end
      hold = 1'b0;
      if (sent_all)
        check($sformatf("v%0d_ready_flush", idx), 32'(o_ready), 32'd0);
      if (o_valid && i_ready) begin
        esym = v.exp[31-4*k -: 4];
        check($sformatf("v%0d_sym%0d", idx, k), 32'(o_symbol), 32'(esym));
        check($sformatf("v%0d_mod%0d", idx, k), 32'(o_mod), 32'(v.mod));
        check($sformatf("v%0d_last%0d", idx, k), 32'(o_last), 32'(k == v.nexp - 1));
        k++;
      end else if (o_valid) begin
        hold  = 1'b1;
        hsym  = o_symbol;
        hlast = o_last;
      end
      if (wi < v.nw) begin
        i_valid = 1'b1;
        i_data  = v.words[23-8*wi -: 8];
        i_last  = (wi == v.nw - 1);
        i_mod   = (wi == 0) ? v.mod : v.mod2;
        if (o_ready) begin
          wi++;
          if (wi == v.nw) sent_all = 1'b1;
        end
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
      end
    end
    if (k < v.nexp)
      check($sformatf("v%0d_timeout_symbols", idx), 32'(k), 32'(v.nexp));
    @(negedge iclk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    check($sformatf("v%0d_no_extra", idx), 32'(o_valid), 32'd0);
    check($sformatf("v%0d_ready_idle", idx), 32'(o_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{2'd1, 2'd1, 1, 24'hB40000, 4, 32'h2310_0000, 1'b0}; // QPSK
    vecs[1] = '{2'd2, 2'd2, 1, 24'hB70000, 3, 32'h5560_0000, 1'b0}; // PSK8 padded
    vecs[2] = '{2'd3, 2'd3, 2, 24'h3CA500, 4, 32'h3CA5_0000, 1'b0}; // QAM16 two words
    vecs[3] = '{2'd0, 2'd0, 1, 24'h810000, 8, 32'h1000_0001, 1'b1}; // BPSK backpressure
    vecs[4] = '{2'd1, 2'd3, 2, 24'h1BE400, 8, 32'h0123_3210, 1'b0}; // mod change ignored
    vecs[5] = '{2'd3, 2'd3, 1, 24'h5E0000, 2, 32'h5E00_0000, 1'b0}; // next frame QAM16
    vecs[6] = '{2'd2, 2'd2, 2, 24'hFF0100, 6, 32'h7760_0400, 1'b0}; // PSK8 residue over 2 words
    vecs[7] = '{2'd0, 2'd0, 1, 24'hA50000, 8, 32'h1010_0101, 1'b0}; // BPSK
    vecs[8] = '{2'd2, 2'd2, 3, 24'h924924, 8, 32'h4444_4444, 1'b0}; // PSK8 exact, no pad

    ireset_n = 1'b0;
    i_mod    = 2'd0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_last   = 1'b0;
    i_ready  = 1'b1;
    #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_symbol", 32'(o_symbol), 32'd0);
    check("rst_mod", 32'(o_mod), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    repeat (2) @(negedge iclk);
    ireset_n = 1'b1;
    @(negedge iclk);
    check("ready_after_rst", 32'(o_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);

    // Reset mid-frame with 5 PSK8 bits still buffered
    @(negedge iclk);
    i_valid = 1'b1; i_data = 8'hF0; i_mod = 2'd2; i_last = 1'b0; i_ready = 1'b1;
    check("mr_ready", 32'(o_ready), 32'd1);
    @(negedge iclk);
    i_valid = 1'b0;
    check("mr_sym0", 32'(o_symbol), 32'd7);
    @(negedge iclk);
    i_ready = 1'b0;
    check("mr_valid5", 32'(o_valid), 32'd1);
    check("mr_sym1", 32'(o_symbol), 32'd4);
    ireset_n = 1'b0;
    #1;
    check("mr_valid_rst", 32'(o_valid), 32'd0);
    check("mr_ready_rst", 32'(o_ready), 32'd0);
    check("mr_symbol_rst", 32'(o_symbol), 32'd0);
    @(negedge iclk);
    ireset_n = 1'b1;
    i_ready  = 1'b1;
    @(negedge iclk);
    check("mr_ready_rise", 32'(o_ready), 32'd1);
    check("mr_valid_idle", 32'(o_valid), 32'd0);
    run_frame(9, '{2'd3, 2'd3, 1, 24'hC30000, 2, 32'hC300_0000, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
